// File: rtl/inst_enc.sv
// inst_enc: encodes RV32I instruction fields into 32-bit words and writes them
// sequentially into an instruction memory, one word per two cycles.
module inst_enc #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    cls,
  input  logic [3:0]    alu_op,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_data,
  output logic          err,
  output logic          full,
  output logic [AW:0]   cnt
);
  typedef enum logic [1:0] {IDLE, WR, FULL} state_t;
  state_t state;
  logic [AW-1:0] ptr;
  logic [31:0] enc;
  logic bad;
  logic [2:0] f3;
  assign f3 = alu_op[2:0];
  always_comb begin
    enc = '0;
    bad = 1'b0;
    case (cls)
      3'd0: begin
        enc = {1'b0, alu_op[3], 5'b0, rs2, rs1, f3, rd, 7'b0110011};
        bad = alu_op[3] && f3 != 3'b000 && f3 != 3'b101;
      end
      3'd1: begin
        enc = f3 == 3'b001 ? {7'b0, imm[4:0], rs1, 3'b001, rd, 7'b0010011} :
              f3 == 3'b101 ? {1'b0, alu_op[3], 5'b0, imm[4:0], rs1, 3'b101, rd, 7'b0010011} :
                             {imm[11:0], rs1, f3, rd, 7'b0010011};
        bad = alu_op[3] && f3 != 3'b101;
      end
      3'd2: enc = {imm[31:12], rd, 7'b0110111};
      3'd3: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd4: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd5: begin
        enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        bad = imm[0];
      end
      3'd6: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        bad = imm[0];
      end
      3'd7: enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
    endcase
  end
  // im_data only loads on a legal accept, so it holds between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      im_data <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clear) begin
        state <= IDLE;
        ptr   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            if (bad) err <= 1'b1;
            else begin
              im_data <= enc;
              state   <= WR;
            end
          end
          WR: begin
            ptr   <= ptr + 1'b1;
            cnt   <= cnt + 1'b1;
            state <= &ptr ? FULL : IDLE;
          end
          default: ;
        endcase
      end
    end
  end
  assign im_we    = state == WR;
  assign im_addr  = ptr;
  assign in_ready = state == IDLE;
  assign full     = state == FULL;
endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: scoreboard bench for inst_enc; expected writes are queued at
// accept time from an independent field-shifting model and popped on im_we.
module tb_inst_enc;
  localparam int AW = 6;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0;
  logic in_ready, im_we, err, full;
  logic [2:0] cls = '0;
  logic [3:0] alu_op = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0, im_data;
  logic [AW-1:0] im_addr;
  logic [AW:0] cnt;
  int n_chk = 0, n_fail = 0;
  logic [AW+31:0] q[$];
  logic [AW-1:0] exp_ptr = '0;

  inst_enc #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .cls(cls), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
    .err(err), .full(full), .cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [2:0] c, input logic [3:0] a,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] i);
    logic [31:0] w, rdf, r1, r2, f3, hi;
    logic ok;
    rdf = 32'(d) << 7;
    r1 = 32'(s1) << 15;
    r2 = 32'(s2) << 20;
    f3 = 32'(a[2:0]) << 12;
    hi = 32'(a[3]) << 30;
    ok = 1'b1;
    w = '0;
    case (c)
      3'd0: begin
        w = 32'h33 | rdf | f3 | r1 | r2 | hi;
        ok = !a[3] || a[2:0] == 3'd0 || a[2:0] == 3'd5;
      end
      3'd1: begin
        if (a[2:0] == 3'd1) w = 32'h1013 | rdf | r1 | (32'(i[4:0]) << 20);
        else if (a[2:0] == 3'd5) w = 32'h5013 | rdf | r1 | (32'(i[4:0]) << 20) | hi;
        else w = 32'h13 | rdf | f3 | r1 | (32'(i[11:0]) << 20);
        ok = !a[3] || a[2:0] == 3'd5;
      end
      3'd2: w = (i & 32'hFFFFF000) | rdf | 32'h37;
      3'd3: w = (32'(i[11:0]) << 20) | r1 | 32'h2000 | rdf | 32'h03;
      3'd4: w = (32'(i[11:5]) << 25) | r2 | r1 | 32'h2000 | (32'(i[4:0]) << 7) | 32'h23;
      3'd5: begin
        w = (32'(i[12]) << 31) | (32'(i[10:5]) << 25) | r2 | r1 | (32'(i[4:1]) << 8) | (32'(i[11]) << 7) | 32'h63;
        ok = !i[0];
      end
      3'd6: begin
        w = (32'(i[20]) << 31) | (32'(i[10:1]) << 21) | (32'(i[11]) << 20) | (32'(i[19:12]) << 12) | rdf | 32'h6F;
        ok = !i[0];
      end
      default: w = (32'(i[11:0]) << 20) | r1 | rdf | 32'h67;
    endcase
    return {ok, w};
  endfunction

  always @(negedge clk) if (im_we) begin
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_write addr=%0d data=%h", im_addr, im_data);
    end else begin
      logic [AW+31:0] e;
      e = q.pop_front();
      if ({im_addr, im_data} !== e) begin
        n_fail++;
        $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h", im_addr, im_data, e[AW+31:32], e[31:0]);
      end
    end
  end

  // leaves inputs idle 1ns after the accepting edge
  task automatic send(input logic [2:0] c, input logic [3:0] a, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] i, input bit push);
    logic [32:0] m;
    int k;
    m = model(c, a, d, s1, s2, i);
    for (k = 0; k < 10 && !in_ready; k++) begin @(posedge clk); #1; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout in_ready=%b exp 1", in_ready);
      return;
    end
    cls = c; alu_op = a; rd = d; rs1 = s1; rs2 = s2; imm = i; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    if (m[32] && push) begin
      q.push_back({exp_ptr, m[31:0]});
      exp_ptr++;
    end
    if (!m[32]) begin
      n_chk++;
      if (err !== 1 || im_we !== 0 || in_ready !== 1) begin
        n_fail++;
        $display("FAIL illegal_accept err=%b we=%b rdy=%b exp 1 0 1", err, im_we, in_ready);
      end
    end
  endtask

  task automatic do_clear;
    @(posedge clk); #1;
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    exp_ptr = '0;
  endtask

  task automatic chk_now(input string name, input logic [AW:0] ecnt, input logic [31:0] edata, input logic [AW-1:0] eaddr);
    n_chk++;
    if (im_we !== 1 || im_data !== edata || im_addr !== eaddr) begin
      n_fail++;
      $display("FAIL %s we=%b addr=%0d data=%h exp 1 %0d %h", name, im_we, im_addr, im_data, eaddr, edata);
    end
    @(posedge clk); #1;
    n_chk++;
    if (cnt !== ecnt || im_we !== 0) begin
      n_fail++;
      $display("FAIL %s_cnt cnt=%0d we=%b exp %0d 0", name, cnt, im_we, ecnt);
    end
  endtask

  task automatic test_reset;
    #1;
    n_chk++;
    if (im_we !== 0 || im_addr !== 0 || im_data !== 0 || err !== 0 || full !== 0 || cnt !== 0) begin
      n_fail++;
      $display("FAIL reset we=%b addr=%0d data=%h err=%b full=%b cnt=%0d exp all 0", im_we, im_addr, im_data, err, full, cnt);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1) begin
      n_fail++;
      $display("FAIL reset_ready in_ready=%b exp 1", in_ready);
    end
  endtask

  task automatic test_r;
    send(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    chk_now("r_add", 7'd1, 32'h002081B3, 6'd0);
    send(3'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    chk_now("r_sub", 7'd2, 32'h402081B3, 6'd1);
    send(3'd0, 4'b1001, 5'd3, 5'd1, 5'd2, 32'd0, 1);
  endtask

  task automatic test_lui_sw;
    send(3'd2, 4'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1);
    chk_now("lui", 7'd3, 32'h123452B7, 6'd2);
    send(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1);
    chk_now("sw", 7'd4, 32'h0020A423, 6'd3);
  endtask

  task automatic test_beq;
    send(3'd5, 4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1);
    chk_now("beq", 7'd5, 32'h00208463, 6'd4);
    send(3'd5, 4'd0, 5'd0, 5'd1, 5'd2, 32'd7, 1);
    @(posedge clk); #1;
    n_chk++;
    if (err !== 0 || cnt !== 5 || im_we !== 0 || im_addr !== 5) begin
      n_fail++;
      $display("FAIL beq_odd err=%b cnt=%0d we=%b addr=%0d exp 0 5 0 5", err, cnt, im_we, im_addr);
    end
  endtask

  task automatic test_imm;
    send(3'd1, 4'b1000, 5'd1, 5'd1, 5'd0, 32'd3, 1);
    @(posedge clk); #1;
    n_chk++;
    if (err !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL imm_err_pulse err=%b rdy=%b exp 0 1", err, in_ready);
    end
    send(3'd1, 4'b1101, 5'd1, 5'd1, 5'd0, 32'd3, 1);
    chk_now("srai", 7'd6, 32'h4030D093, 6'd5);
    send(3'd1, 4'b0001, 5'd7, 5'd9, 5'd0, 32'd17, 1);
    send(3'd6, 4'd0, 5'd1, 5'd0, 5'd0, 32'h000FF7FE, 1);
    send(3'd7, 4'd0, 5'd1, 5'd4, 5'd0, 32'hFFFFF800, 1);
    send(3'd3, 4'd0, 5'd2, 5'd3, 5'd0, 32'h00000ABC, 1);
  endtask

  task automatic test_back_to_back;
    int words = 0;
    do_clear();
    n_chk++;
    if (cnt !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL clear cnt=%0d rdy=%b exp 0 1", cnt, in_ready);
    end
    for (int n = 0; n < 400 && words < 64; n++) begin
      logic [32:0] m;
      logic [2:0] c;
      logic [3:0] a;
      logic [31:0] i;
      c = 3'($urandom_range(0, 7));
      a = 4'($urandom_range(0, 15));
      i = $urandom;
      m = model(c, a, 5'($urandom), 5'($urandom), 5'($urandom), i);
      send(c, a, 5'(n), 5'(n + 3), 5'(n + 7), i, 1);
      if (m[32]) words++;
    end
    @(posedge clk); #1;
    n_chk++;
    if (full !== 1 || cnt !== 64 || in_ready !== 0 || im_we !== 0) begin
      n_fail++;
      $display("FAIL full full=%b cnt=%0d rdy=%b we=%b exp 1 64 0 0", full, cnt, in_ready, im_we);
    end
    do_clear();
    n_chk++;
    if (full !== 0 || cnt !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL full_clear full=%b cnt=%0d rdy=%b exp 0 0 1", full, cnt, in_ready);
    end
    send(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    chk_now("after_clear", 7'd1, 32'h002081B3, 6'd0);
  endtask

  task automatic test_rst_mid_wr;
    send(3'd2, 4'd0, 5'd5, 5'd0, 5'd0, 32'hABCDE000, 0);
    n_chk++;
    if (im_we !== 1) begin
      n_fail++;
      $display("FAIL rst_pre we=%b exp 1", im_we);
    end
    rst = 1;
    #1;
    n_chk++;
    if (im_we !== 0 || cnt !== 0 || im_addr !== 0 || im_data !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_wr we=%b cnt=%0d addr=%0d data=%h exp 0 0 0 0", im_we, cnt, im_addr, im_data);
    end
    @(posedge clk); #1;
    rst = 0;
    exp_ptr = '0;
    send(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1);
    chk_now("post_rst", 7'd1, 32'h0020A423, 6'd0);
  endtask

  initial begin
    test_reset();
    test_r();
    test_lui_sw();
    test_beq();
    test_imm();
    test_back_to_back();
    test_rst_mid_wr();
    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes pending=%0d exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
